instr_encoder_loader: RTL and testbench



---
 rtl/instr_encoder_loader.sv | 185 ++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Packs RV32I instruction fields from a valid/ready stream into
//               32-bit words by opcode class. Each word is written in turn to
//               the instruction memory write port, starting at BASE_ADDR.
//               Illegal or out-of-range input is still written, and is
//               flagged in a sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 1024,
    localparam int         CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic [CNT_W-1:0] word_count,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_index
);

    localparam logic [6:0]       c_OP_R     = 7'b0110011;
    localparam logic [6:0]       c_OP_I     = 7'b0010011;
    localparam logic [6:0]       c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0]       c_OP_JALR  = 7'b1100111;
    localparam logic [6:0]       c_OP_S     = 7'b0100011;
    localparam logic [6:0]       c_OP_B     = 7'b1100011;
    localparam logic [6:0]       c_OP_LUI   = 7'b0110111;
    localparam logic [6:0]       c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0]       c_OP_J     = 7'b1101111;
    localparam logic [31:0]      c_NOP      = 32'h0000_0013;
    localparam logic [CNT_W-1:0] c_MAX      = CNT_W'(MAX_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_count;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_err_index;

    logic             w_ready;
    logic [31:0]      w_word;
    logic             w_bad;
    logic             w_fit12;
    logic             w_fit13;
    logic             w_fit21;

    // An immediate sign-fits N bits when bits [31:N-1] are all copies of the sign
    assign w_fit12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign w_fit13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign w_fit21 = (&imm[31:20]) | ~(|imm[31:20]);

    assign w_ready = (r_state == ST_LOAD) && (r_count < c_MAX);

    // Encode the current bundle by opcode class and flag out-of-range immediates
    always_comb begin
        w_word = c_NOP;
        w_bad  = 1'b0;
        case (opcode)
            c_OP_R: begin
                w_word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            c_OP_I, c_OP_LOAD, c_OP_JALR: begin
                w_word = {imm[11:0], rs1, funct3, rd, opcode};
                w_bad  = ~w_fit12;
            end
            c_OP_S: begin
                w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                w_bad  = ~w_fit12;
            end
            c_OP_B: begin
                w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                w_bad  = ~w_fit13 | imm[0];
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_word = {imm[31:12], rd, opcode};
                w_bad  = |imm[11:0];
            end
            c_OP_J: begin
                w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                w_bad  = ~w_fit21 | imm[0];
            end
            default: begin
                w_word = c_NOP;
                w_bad  = 1'b1;
            end
        endcase
    end

    // Load sequencer: start restarts from any state and drops a same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_index <= '0;
        end else begin
            r_we <= 1'b0;
            if (start) begin
                r_state     <= ST_LOAD;
                r_addr      <= 32'h0;
                r_wdata     <= 32'h0;
                r_count     <= '0;
                r_done      <= 1'b0;
                r_err       <= 1'b0;
                r_err_index <= '0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (in_valid && w_ready) begin
                            r_we    <= 1'b1;
                            r_addr  <= BASE_ADDR + (32'(r_count) << 2);
                            r_wdata <= w_word;
                            r_count <= r_count + CNT_W'(1);
                            if (w_bad) begin
                                r_err <= 1'b1;
                                if (!r_err) begin
                                    r_err_index <= r_count;
                                end
                            end
                            if (in_last) begin
                                r_state <= ST_DRAIN;
                            end
                        end else if (in_valid) begin
                            // Capacity exhausted: refuse and terminate the load
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                            if (!r_err) begin
                                r_err_index <= r_count;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign in_ready   = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign word_count = r_count;
    assign done       = r_done;
    assign err        = r_err;
    assign err_index  = r_err_index;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_loader
// Description : Self-checking bench for instr_encoder_loader. Two instances
//               share one input stream: a default one and a small one
//               (MAX_WORDS=4, nonzero base) so that overflow can be exercised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam int          MAX_A  = 1024;
    localparam logic [31:0] BASE_B = 32'h0000_1000;
    localparam int          MAX_B  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [6:0]  opcode = 7'h0;
    logic [4:0]  rd = 5'h0;
    logic [4:0]  rs1 = 5'h0;
    logic [4:0]  rs2 = 5'h0;
    logic [2:0]  funct3 = 3'h0;
    logic [6:0]  funct7 = 7'h0;
    logic [31:0] imm = 32'h0;

    logic        a_ready, a_we, a_done, a_err;
    logic [31:0] a_addr, a_wdata;
    logic [10:0] a_count, a_eidx;
    logic        b_ready, b_we, b_done, b_err;
    logic [31:0] b_addr, b_wdata;
    logic [2:0]  b_count, b_eidx;

    instr_encoder_loader #(.BASE_ADDR(BASE_A), .MAX_WORDS(MAX_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(a_ready),
        .in_last(in_last), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .word_count(a_count), .done(a_done), .err(a_err), .err_index(a_eidx)
    );

    instr_encoder_loader #(.BASE_ADDR(BASE_B), .MAX_WORDS(MAX_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(b_ready),
        .in_last(in_last), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .word_count(b_count), .done(b_done), .err(b_err), .err_index(b_eidx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state, one slot per instance
    int          m_max [2];
    logic [31:0] m_base [2];
    bit          m_active [2];
    bit          m_finish [2];
    bit          m_done [2];
    bit          m_err [2];
    bit          m_we [2];
    int          m_count [2];
    int          m_eidx [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  d;
        logic [2:0]  f3;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [6:0]  f7;
        logic [31:0] im;
        logic [31:0] exp_word;
        logic        exp_bad;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Field packing from the instruction-format rules, using shifts and masks
    function automatic void ref_encode(input logic [6:0] op, input logic [4:0] d,
                                       input logic [2:0] f3, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [6:0] f7,
                                       input logic [31:0] im,
                                       output logic [31:0] w, output bit bad);
        int          v;
        logic [31:0] regs;
        v    = $signed(im);
        regs = 32'(op) | (32'(f3) << 12) | (32'(s1) << 15);
        bad  = 1'b0;
        case (op)
            7'h33: w = regs | (32'(d) << 7) | (32'(s2) << 20) | (32'(f7) << 25);
            7'h13, 7'h03, 7'h67: begin
                w   = regs | (32'(d) << 7) | ((im & 32'hFFF) << 20);
                bad = (v < -2048) || (v > 2047);
            end
            7'h23: begin
                w   = regs | (32'(s2) << 20) | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
                bad = (v < -2048) || (v > 2047);
            end
            7'h63: begin
                w   = regs | (32'(s2) << 20) | (((im >> 12) & 32'h1) << 31)
                    | (((im >> 5) & 32'h3F) << 25) | (((im >> 1) & 32'hF) << 8)
                    | (((im >> 11) & 32'h1) << 7);
                bad = (v < -4096) || (v > 4095) || ((im & 32'h1) != 0);
            end
            7'h37, 7'h17: begin
                w   = (im & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
                bad = (im & 32'hFFF) != 0;
            end
            7'h6F: begin
                w   = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 32'h1) << 20) | (im & 32'h000F_F000)
                    | (32'(d) << 7) | 32'(op);
                bad = (v < -1048576) || (v > 1048575) || ((im & 32'h1) != 0);
            end
            default: begin
                w   = 32'h0000_0013;
                bad = 1'b1;
            end
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_finish[i] = 0; m_done[i] = 0; m_err[i] = 0;
            m_we[i] = 0; m_count[i] = 0; m_eidx[i] = 0;
        end
    endfunction

    // Predicts what instance i shows after the coming clock edge
    function automatic void model_edge(input int i);
        logic [31:0] w;
        bit          bad;
        m_we[i] = 0;
        if (start) begin
            m_count[i] = 0; m_err[i] = 0; m_eidx[i] = 0; m_done[i] = 0;
            m_active[i] = 1; m_finish[i] = 0;
        end else if (m_finish[i]) begin
            m_finish[i] = 0;
            m_done[i] = 1;
        end else if (m_active[i] && in_valid) begin
            if (m_count[i] < m_max[i]) begin
                ref_encode(opcode, rd, funct3, rs1, rs2, funct7, imm, w, bad);
                m_we[i] = 1;
                m_addr[i] = m_base[i] + 32'(m_count[i] * 4);
                m_wdata[i] = w;
                if (bad) begin
                    if (!m_err[i]) m_eidx[i] = m_count[i];
                    m_err[i] = 1;
                end
                m_count[i]++;
                if (in_last) begin
                    m_active[i] = 0;
                    m_finish[i] = 1;
                end
            end else begin
                if (!m_err[i]) m_eidx[i] = m_count[i];
                m_err[i] = 1;
                m_done[i] = 1;
                m_active[i] = 0;
            end
        end
    endfunction

    task automatic check_dut(input int i);
        logic        rdy, we, dn, er;
        logic [31:0] ad, wd, cnt, eix;
        string       t;
        if (i == 0) begin
            t = "A"; rdy = a_ready; we = a_we; dn = a_done; er = a_err;
            ad = a_addr; wd = a_wdata; cnt = 32'(a_count); eix = 32'(a_eidx);
        end else begin
            t = "B"; rdy = b_ready; we = b_we; dn = b_done; er = b_err;
            ad = b_addr; wd = b_wdata; cnt = 32'(b_count); eix = 32'(b_eidx);
        end
        chk({t, ".imem_we"}, 32'(we), 32'(m_we[i]));
        if (m_we[i]) begin
            chk({t, ".imem_addr"}, ad, m_addr[i]);
            chk({t, ".imem_wdata"}, wd, m_wdata[i]);
        end
        chk({t, ".word_count"}, cnt, 32'(m_count[i]));
        chk({t, ".done"}, 32'(dn), 32'(m_done[i]));
        chk({t, ".err"}, 32'(er), 32'(m_err[i]));
        chk({t, ".err_index"}, eix, 32'(m_eidx[i]));
        chk({t, ".in_ready"}, 32'(rdy), 32'(m_active[i] && (m_count[i] < m_max[i])));
    endtask

    task automatic step();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                         input logic [31:0] im, input logic last);
        opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
        in_last = last; in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    endtask

    task automatic do_start();
        idle();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " A.we"}, 32'(a_we), 32'h0);
        chk({tag, " A.addr"}, a_addr, 32'h0);
        chk({tag, " A.wdata"}, a_wdata, 32'h0);
        chk({tag, " A.count"}, 32'(a_count), 32'h0);
        chk({tag, " A.flags"}, {28'h0, a_ready, a_done, a_err, 1'b0}, 32'h0);
        chk({tag, " A.eidx"}, 32'(a_eidx), 32'h0);
        chk({tag, " B.we"}, 32'(b_we), 32'h0);
        chk({tag, " B.addr"}, b_addr, 32'h0);
        chk({tag, " B.count"}, 32'(b_count), 32'h0);
        chk({tag, " B.flags"}, {28'h0, b_ready, b_done, b_err, 1'b0}, 32'h0);
    endtask

    localparam logic [6:0] LEGAL_OPS [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    localparam int         EDGE_IMMS [12] = '{2047, 2048, -2048, -2049, 4095, 4096, -4096, -4097,
                                              1048575, 1048576, -1048576, -1048577};

    initial begin
        m_max[0] = MAX_A; m_base[0] = BASE_A;
        m_max[1] = MAX_B; m_base[1] = BASE_B;
        model_reset();

        vecs[0]  = '{7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5,         32'h0050_0093, 1'b0};
        vecs[1]  = '{7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8,         32'h0020_A423, 1'b0};
        vecs[2]  = '{7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
        vecs[3]  = '{7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048,      32'h0010_00EF, 1'b0};
        vecs[4]  = '{7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        vecs[5]  = '{7'h7F, 5'd3, 3'd1, 5'd2, 5'd1, 7'd0, 32'd0,         32'h0000_0013, 1'b1};
        vecs[6]  = '{7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048,      32'h8000_0093, 1'b1};
        vecs[7]  = '{7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0,         32'h0020_81B3, 1'b0};
        vecs[8]  = '{7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'd0,        32'h4020_81B3, 1'b0};
        vecs[9]  = '{7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3,         32'h0000_0163, 1'b1};
        vecs[10] = '{7'h37, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_1001, 32'h0000_10B7, 1'b1};
        vecs[11] = '{7'h67, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'hFFFF_F800, 32'h8001_00E7, 1'b0};
        vecs[12] = '{7'h03, 5'd4, 3'd2, 5'd5, 5'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF2_A203, 1'b0};
        vecs[13] = '{7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0010_0000, 32'h8000_006F, 1'b1};
        vecs[14] = '{7'h17, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_F000, 32'hFFFF_F117, 1'b0};

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single-instruction encodings
        for (int k = 0; k < 15; k++) begin
            do_start();
            drive(vecs[k].op, vecs[k].d, vecs[k].f3, vecs[k].s1, vecs[k].s2, vecs[k].f7,
                  vecs[k].im, 1'b0);
            step();
            idle();
            chk($sformatf("vec%0d wdata", k), a_wdata, vecs[k].exp_word);
            chk($sformatf("vec%0d err", k), 32'(a_err), 32'(vecs[k].exp_bad));
            chk($sformatf("vec%0d addrB", k), b_addr, BASE_B);
        end

        // addi, sw, beq back to back: consecutive addresses, no gap
        do_start();
        drive(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1'b0);
        step();
        chk("seq addi addr", a_addr, 32'h0);
        chk("seq addi data", a_wdata, 32'h0050_0093);
        drive(7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 1'b0);
        step();
        chk("seq sw we", 32'(a_we), 32'h1);
        chk("seq sw addr", a_addr, 32'h4);
        chk("seq sw data", a_wdata, 32'h0020_A423);
        drive(7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFC, 1'b0);
        step();
        chk("seq beq we", 32'(a_we), 32'h1);
        chk("seq beq addr", a_addr, 32'h8);
        chk("seq beq data", a_wdata, 32'hFE00_0EE3);
        idle();
        step();

        // jal with in_last, done the cycle after the write; restart with lui
        do_start();
        drive(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 1'b1);
        step();
        idle();
        chk("last we", 32'(a_we), 32'h1);
        chk("last data", a_wdata, 32'h0010_00EF);
        chk("last done early", 32'(a_done), 32'h0);
        step();
        chk("last done", 32'(a_done), 32'h1);
        chk("last ready", 32'(a_ready), 32'h0);
        step();
        chk("done held", 32'(a_done), 32'h1);
        do_start();
        chk("restart done clr", 32'(a_done), 32'h0);
        drive(7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000, 1'b0);
        step();
        idle();
        chk("restart addr", a_addr, BASE_A);
        chk("restart data", a_wdata, 32'h1234_52B7);
        chk("restart addrB", b_addr, BASE_B);

        // Illegal opcode then out-of-range addi: err_index stays at the first error
        do_start();
        drive(7'h7F, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0, 1'b0);
        step();
        chk("illegal nop", a_wdata, 32'h0000_0013);
        chk("illegal err", 32'(a_err), 32'h1);
        drive(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 1'b0);
        step();
        idle();
        chk("second err idx", 32'(a_eidx), 32'h0);
        chk("second err cnt", 32'(a_count), 32'h2);

        // Overflow on the small instance
        do_start();
        for (int k = 0; k < 5; k++) begin
            drive(7'h13, 5'(k), 3'd0, 5'd0, 5'd0, 7'd0, 32'(k), 1'b0);
            step();
            if (k < 4) begin
                chk($sformatf("ovf we%0d", k), 32'(b_we), 32'h1);
                chk($sformatf("ovf addr%0d", k), b_addr, BASE_B + 32'(4 * k));
            end
        end
        idle();
        chk("ovf we", 32'(b_we), 32'h0);
        chk("ovf err", 32'(b_err), 32'h1);
        chk("ovf done", 32'(b_done), 32'h1);
        chk("ovf eidx", 32'(b_eidx), 32'h4);
        chk("ovf ready", 32'(b_ready), 32'h0);
        step();

        // start in the middle of a valid stream drops that cycle's write
        do_start();
        drive(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 1'b0);
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start drop we", 32'(a_we), 32'h0);
        chk("start drop cnt", 32'(a_count), 32'h0);
        step();
        chk("after start we", 32'(a_we), 32'h1);
        chk("after start addr", a_addr, 32'h0);

        // Asynchronous reset while a write is on the port
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        idle();
        check_all_zero("async rst");
        #3;
        rst_n = 1'b1;
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [6:0]  op;
            logic [31:0] im;
            start = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) op = 7'($urandom_range(0, 127));
            else op = LEGAL_OPS[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0: im = 32'($signed(32'($urandom_range(0, 8191))) - 4096) & ~32'($urandom_range(0, 1));
                1: im = 32'(EDGE_IMMS[$urandom_range(0, 11)]);
                2: im = $urandom;
                default: im = $urandom & 32'hFFFF_F000;
            endcase
            drive(op, 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 7'($urandom),
                  im, ($urandom_range(0, 31) == 0));
            in_valid = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
